module_keypad_scanner: RTL and testbench
========================================

// Module: module_keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low matrix keypad using an internal COUNT-cycle tick prescaler.
//  Debounces the press and release of each key.
//  Hands the 4-bit key code to the multiplier operand-entry logic over a valid/ready handshake.
//  Sits between the board keypad pins and the operand registers; the only consumer of the scan tick.
// PARAMETERS
//  COUNT     13500  clk cycles per scan tick (27 MHz -> 0.5 ms); legal range >= 2
//  DEBOUNCE  8      consecutive identical tick samples needed to accept a press or a release; legal range >= 2
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  col_in     in   4  keypad columns, raw pad inputs, active-low (pulled up)
//  row_out    out  4  keypad rows; exactly one bit low = driven row
//  key_code   out  4  {row[1:0], col[1:0]} of the accepted key
//  key_valid  out  1  key_code holds an unconsumed key
//  key_ready  in   1  consumer accepts key_code
//  overrun    out  1  1-cycle pulse: key accepted while key_valid still high, new key dropped
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=SCAN, row_idx=0, row_out=4'b1110.
//   - key_code=0, key_valid=0, overrun=0.
//   - tick counter=0, db_cnt=0, rel_cnt=0, sync flops=4'b1111.
//  Tick generation:
//   - cnt runs 0..COUNT-1 and wraps.
//   - tick=1 for exactly one cycle when cnt==COUNT-1; it is the only sample point.
//  Column path:
//   - col_in passes through a 2-flop synchroniser -> col_s.
//   - With several columns low, the lowest column index wins.
//  row_out = ~(4'b0001 << row_idx), registered; changes only on tick.
//  FSM (all transitions on tick only; no action between ticks):
//   SCAN:
//    - col_s==4'b1111 -> row_idx = row_idx+1 (wraps 3->0).
//    - any col low -> latch row_idx, col_idx; db_cnt=1; -> DEBOUNCE (row held).
//   DEBOUNCE:
//    - col_s[col_idx]==0 and db_cnt==DEBOUNCE-1 -> accept key; rel_cnt=0; -> HOLD.
//    - col_s[col_idx]==0 otherwise -> db_cnt++.
//    - col_s[col_idx]==1 -> glitch: row_idx++; -> SCAN. Nothing emitted.
//   HOLD (row held):
//    - col_s[col_idx]==1 -> rel_cnt++.
//    - col_s[col_idx]==0 -> rel_cnt=0.
//    - rel_cnt reaches DEBOUNCE -> row_idx++; -> SCAN.
//    - A held key never repeats.
//  Accept, in the cycle after the accepting tick:
//   - key_valid==0 -> key_code={row_idx,col_idx}, key_valid=1.
//   - key_valid==1 -> key_code unchanged; overrun=1 for one cycle.
//  Handshake:
//   - key_valid && key_ready at a clk edge -> key_valid=0 next cycle.
//   - key_code is stable while key_valid=1.
//   - Accept and handshake in the same cycle: the handshake completes first, the new key
//     loads, key_valid stays 1, no overrun.
//  Latency:
//   - From the detecting tick, key_valid rises 1 clk after the (DEBOUNCE-1)th following tick.
//   - Detection needs <= 4 ticks of row scan.
//  Mid-operation reset: async rst=0 forces every reset value immediately, any pending key_valid included.
// TESTING  (COUNT=4, DEBOUNCE=3 unless noted)
//  1 Reset/idle:
//    - rst low then high, col_in=4'hF.
//    - row_out steps 1110->1101->1011->0111->1110, one step per 4 clk.
//    - key_valid stays 0.
//  2 Clean press, key_ready=1:
//    - col_in=4'b1101 while row 2 is driven, held 20 ticks.
//    - key_code=4'h9, key_valid high exactly 1 cycle, asserted 1 clk after the 2nd tick after detection.
//    - No repeat while held.
//  3 Bounce:
//    - col low 1 tick then high.
//    - No key_valid; scan resumes at the next row.
//    - Release bounce inside HOLD (high 2 ticks, low 1) gives no re-trigger.
//  4 Overrun:
//    - key_ready=0; press/release key 0, then press key 5.
//    - key_code stays 0, key_valid stays 1, overrun pulses once.
//    - After key_ready=1, key_valid drops.
//  5 Multi-key:
//    - col_in=4'b1010 on row 1 -> key_code=4'h4 (lowest column).
//  6 Reset mid-DEBOUNCE and with key_valid=1:
//    - All outputs return to reset values in the same cycle rst falls.
//    - A fresh press after release is decoded normally.

Source files
------------

// File: rtl/module_keypad_scanner_if.sv
// rtl/module_keypad_scanner_if.sv - key code valid/ready handshake between scanner and operand entry
interface module_keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/module_keypad_scanner.sv
// rtl/module_keypad_scanner.sv - 4x4 active-low keypad scanner with tick prescaler, debounce and key handshake
module module_keypad_scanner #(
    parameter int COUNT    = 13500,
    parameter int DEBOUNCE = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               col_in,
    output logic [3:0]               row_out,
    module_keypad_scanner_if.master  key
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COUNT - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [DW-1:0] rel_cnt_q, rel_cnt_d;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic          col_any;
    logic [1:0]    lo_col;
    logic          col_hit;
    logic          accept;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pads idle high, so the synchroniser resets to "no column pressed".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    assign col_any = ~&col_s;
    assign col_hit = ~col_s[col_idx_q];

    always_comb begin
        lo_col = 2'd0;
        if (!col_s[0]) begin
            lo_col = 2'd0;
        end else if (!col_s[1]) begin
            lo_col = 2'd1;
        end else if (!col_s[2]) begin
            lo_col = 2'd2;
        end else if (!col_s[3]) begin
            lo_col = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SCAN;
            row_idx_q <= 2'd0;
            col_idx_q <= 2'd0;
            db_cnt_q  <= '0;
            rel_cnt_q <= '0;
            row_out   <= 4'b1110;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            db_cnt_q  <= db_cnt_d;
            rel_cnt_q <= rel_cnt_d;
            row_out   <= ~(4'b0001 << row_idx_d);
        end
    end

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        db_cnt_d  = db_cnt_q;
        rel_cnt_d = rel_cnt_q;
        accept    = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_SCAN: begin
                    if (col_any) begin
                        col_idx_d = lo_col;
                        db_cnt_d  = DW'(1);
                        state_d   = S_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (col_hit) begin
                        if (db_cnt_q == DB_LAST) begin
                            accept    = 1'b1;
                            rel_cnt_d = '0;
                            state_d   = S_HOLD;
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = S_SCAN;
                    end
                end
                S_HOLD: begin
                    // Only a run of DEBOUNCE high samples counts as a release.
                    if (!col_hit) begin
                        if (rel_cnt_q == DB_LAST) begin
                            rel_cnt_d = '0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = S_SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 1'b1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = S_SCAN;
                end
            endcase
        end
    end

    // A same-cycle handshake frees the holding slot, so the new key loads instead of overrunning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key.key_code  <= 4'd0;
            key.key_valid <= 1'b0;
            key.overrun   <= 1'b0;
        end else begin
            key.overrun <= 1'b0;
            if (accept) begin
                if (!key.key_valid || key.key_ready) begin
                    key.key_code  <= {row_idx_q, col_idx_q};
                    key.key_valid <= 1'b1;
                end else begin
                    key.overrun <= 1'b1;
                end
            end else if (key.key_valid && key.key_ready) begin
                key.key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb/tb_module_keypad_scanner.sv - scoreboard bench for module_keypad_scanner with a keypad matrix model
module tb_module_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;
    int ovr_exp = 0;
    logic [3:0] exp_q[$];

    module_keypad_scanner_if kif ();

    module_keypad_scanner #(
        .COUNT   (4),
        .DEBOUNCE(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .col_in (col_in),
        .row_out(row_out),
        .key    (kif)
    );

    always #5 clk = ~clk;

    // Key (r,c) pulls column c low only while row r is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (row_out[r] == 1'b0)) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rowpat(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (kif.overrun === 1'b1) ovr_seen++;
            if (kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("key_expected", 32'(exp_q.size()), 1);
                end else begin
                    chk("key_code", kif.key_code, exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 kif.key_ready = v;
    endtask

    task automatic wait_row(input int r);
        int n;
        n = 0;
        while (row_out == rowpat(r) && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (row_out != rowpat(r) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_row", row_out, rowpat(r));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, kif.key_valid, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"}, row_out, 4'b1110);
        chk({tag, "_valid"}, kif.key_valid, 0);
        chk({tag, "_code"}, kif.key_code, 0);
        chk({tag, "_overrun"}, kif.overrun, 0);
    endtask

    initial begin
        rst = 1'b0;
        keys = '0;
        kif.key_ready = 1'b0;

        // Reset and idle scan
        idle(3);
        chk_reset_outputs("reset");
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("idle_row", row_out, rowpat((k / 4) % 4));
            chk("idle_valid", kif.key_valid, 0);
        end

        // Clean press of key 9 with ready high, then held and release-bounced
        set_ready(1'b1);
        wait_row(2);
        keys[2*4+1] = 1'b1;
        exp_q.push_back(4'h9);
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (j == 11) chk("lat_before", kif.key_valid, 0);
            if (j == 12) chk("lat_valid", kif.key_valid, 1);
            if (j == 13) chk("lat_one_cycle", kif.key_valid, 0);
        end
        idle(80);
        keys[2*4+1] = 1'b0;
        idle(8);
        keys[2*4+1] = 1'b1;
        idle(4);
        keys[2*4+1] = 1'b0;
        idle(40);
        chk("no_repeat_q", 32'(exp_q.size()), 0);

        // One-tick press bounce on row 1
        wait_row(1);
        keys[1*4+0] = 1'b1;
        idle(4);
        chk("bounce_row_held", row_out, rowpat(1));
        keys = '0;
        idle(4);
        chk("bounce_next_row", row_out, rowpat(2));
        idle(20);
        chk("bounce_no_valid", kif.key_valid, 0);

        // Overrun: key 0 unconsumed, then key 5 arrives
        set_ready(1'b0);
        wait_row(0);
        keys[0] = 1'b1;
        exp_q.push_back(4'h0);
        wait_valid("ovr_first_valid");
        idle(8);
        keys = '0;
        idle(40);
        wait_row(1);
        keys[1*4+1] = 1'b1;
        ovr_exp++;
        idle(40);
        chk("ovr_count", ovr_seen, ovr_exp);
        chk("ovr_valid_held", kif.key_valid, 1);
        chk("ovr_code_kept", kif.key_code, 4'h0);
        keys = '0;
        idle(40);
        set_ready(1'b1);
        wait_drain();
        @(negedge clk);
        chk("ovr_valid_drop", kif.key_valid, 0);

        // Two columns low on row 1: lowest column wins
        wait_row(1);
        keys[1*4+0] = 1'b1;
        keys[1*4+2] = 1'b1;
        exp_q.push_back(4'h4);
        wait_drain();
        keys = '0;
        idle(40);

        // Reset while debouncing
        wait_row(3);
        keys[3*4+3] = 1'b1;
        idle(6);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_debounce");
        keys = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(8);

        // Reset with a pending key
        set_ready(1'b0);
        wait_row(2);
        keys[2*4+2] = 1'b1;
        wait_valid("rst_pending_valid");
        chk("rst_pending_code", kif.key_code, 4'hA);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_pending");
        keys = '0;
        @(negedge clk);
        rst = 1'b1;

        // Fresh press after reset decodes normally
        set_ready(1'b1);
        wait_row(3);
        keys[3*4+2] = 1'b1;
        exp_q.push_back(4'hE);
        wait_drain();
        keys = '0;
        idle(40);

        chk("final_overruns", ovr_seen, ovr_exp);
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
